// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_sequencer
// Description : Turns one req/done handshake into a complete multiplexed
//               address/data bus cycle toward an external RTC chip. The
//               address phase always strobes with wr. The data phase strobes
//               with wr for writes and with rd for reads. Read data is taken
//               from ad_in on the clock edge that ends the data strobe.
//               Optional macro RTC_RD_CHECK_EN: takes a second ad_in sample
//               in the middle of the read strobe and flags rd_mismatch in the
//               done cycle if it differs from the final capture.
// Ports       : clk, reset (async, active low)
//               req/we/addr/wdata      : request side, sampled while idle
//               busy/done/rdata        : status and read result
//               rd_mismatch            : read double-sample disagreement
//               ad_out/ad_oe/ad_in     : AD tri-state buffer interface
//               a_d/cs/rd/wr           : RTC bus control pins (cs/rd/wr low)
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 10,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_RECOV = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rd_mismatch,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr
);

  // A parameter value of 0 is treated as a one-cycle phase.
  localparam logic [7:0] c_SETUP = (T_SETUP == 0) ? 8'd1 : 8'(T_SETUP);
  localparam logic [7:0] c_PULSE = (T_PULSE == 0) ? 8'd1 : 8'(T_PULSE);
  localparam logic [7:0] c_HOLD  = (T_HOLD  == 0) ? 8'd1 : 8'(T_HOLD);
  localparam logic [7:0] c_RECOV = (T_RECOV == 0) ? 8'd1 : 8'(T_RECOV);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR_SU   = 4'd1,
    S_ADDR_STB  = 4'd2,
    S_ADDR_HOLD = 4'd3,
    S_DATA_SU   = 4'd4,
    S_DATA_STB  = 4'd5,
    S_DATA_HOLD = 4'd6,
    S_RECOV     = 4'd7
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;

  logic       r_busy;
  logic       r_done;
  logic [7:0] r_rdata;
  logic [7:0] r_ad_out;
  logic       r_ad_oe;
  logic       r_a_d;
  logic       r_cs;
  logic       r_rd;
  logic       r_wr;

  state_t     w_next_state;
  logic [7:0] w_next_cnt;
  logic [7:0] w_len;
  logic       w_last;
  logic       w_accept;
  logic       w_we;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;

  // Transaction attributes as they will be in the next cycle: on the accept
  // edge the registered copies are not loaded yet, so use the raw inputs.
  assign w_accept = (r_state == S_IDLE) && req;
  assign w_we     = w_accept ? we    : r_we;
  assign w_addr   = w_accept ? addr  : r_addr;
  assign w_wdata  = w_accept ? wdata : r_wdata;

  // Length of the phase currently being timed by the shared counter.
  always_comb begin
    w_len = 8'd1;
    case (r_state)
      S_ADDR_SU, S_DATA_SU:     w_len = c_SETUP;
      S_ADDR_STB, S_DATA_STB:   w_len = c_PULSE;
      S_ADDR_HOLD, S_DATA_HOLD: w_len = c_HOLD;
      S_RECOV:                  w_len = c_RECOV;
      default:                  w_len = 8'd1;
    endcase
  end

  assign w_last = (r_cnt == (w_len - 8'd1));

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (r_state == S_IDLE) begin
      w_next_cnt = 8'd0;
      if (req) begin
        w_next_state = S_ADDR_SU;
      end
    end else if (w_last) begin
      w_next_cnt = 8'd0;
      case (r_state)
        S_ADDR_SU:   w_next_state = S_ADDR_STB;
        S_ADDR_STB:  w_next_state = S_ADDR_HOLD;
        S_ADDR_HOLD: w_next_state = S_DATA_SU;
        S_DATA_SU:   w_next_state = S_DATA_STB;
        S_DATA_STB:  w_next_state = S_DATA_HOLD;
        S_DATA_HOLD: w_next_state = S_RECOV;
        default:     w_next_state = S_IDLE;
      endcase
    end else begin
      w_next_cnt = r_cnt + 8'd1;
    end
  end

  // Pin levels are decoded from the state being entered, so every bus pin
  // comes straight from a flop and changes exactly on phase boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_we     <= 1'b0;
      r_addr   <= 8'd0;
      r_wdata  <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= 8'd0;
      r_ad_out <= 8'd0;
      r_ad_oe  <= 1'b0;
      r_a_d    <= 1'b1;
      r_cs     <= 1'b1;
      r_rd     <= 1'b1;
      r_wr     <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end

      r_busy <= (w_next_state != S_IDLE);
      r_done <= (r_state == S_RECOV) && w_last;

      r_a_d    <= 1'b1;
      r_cs     <= 1'b1;
      r_rd     <= 1'b1;
      r_wr     <= 1'b1;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'd0;
      case (w_next_state)
        S_ADDR_SU, S_ADDR_HOLD: begin
          r_a_d    <= 1'b0;
          r_ad_oe  <= 1'b1;
          r_ad_out <= w_addr;
        end
        S_ADDR_STB: begin
          r_a_d    <= 1'b0;
          r_ad_oe  <= 1'b1;
          r_ad_out <= w_addr;
          r_cs     <= 1'b0;
          r_wr     <= 1'b0;
        end
        S_DATA_SU, S_DATA_HOLD: begin
          r_ad_oe  <= w_we;
          r_ad_out <= w_we ? w_wdata : 8'd0;
        end
        S_DATA_STB: begin
          r_cs     <= 1'b0;
          r_wr     <= ~w_we;
          r_rd     <= w_we;
          r_ad_oe  <= w_we;
          r_ad_out <= w_we ? w_wdata : 8'd0;
        end
        default: begin
        end
      endcase

      // Final read capture on the edge that closes the data strobe.
      if ((r_state == S_DATA_STB) && !r_we && w_last) begin
        r_rdata <= ad_in;
      end
    end
  end

`ifdef RTC_RD_CHECK_EN
  localparam logic [7:0] c_PULSE_MID = c_PULSE >> 1;

  logic [7:0] r_mid;
  logic       r_rd_mismatch;

  // r_rdata already holds the final capture by the last RECOV cycle, so the
  // comparison there lines up with the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mid         <= 8'd0;
      r_rd_mismatch <= 1'b0;
    end else begin
      if ((r_state == S_DATA_STB) && !r_we && (r_cnt == c_PULSE_MID)) begin
        r_mid <= ad_in;
      end
      r_rd_mismatch <= (r_state == S_RECOV) && w_last && !r_we &&
                       (r_mid != r_rdata);
    end
  end

  assign rd_mismatch = r_rd_mismatch;
`else
  assign rd_mismatch = 1'b0;
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign rdata  = r_rdata;
  assign ad_out = r_ad_out;
  assign ad_oe  = r_ad_oe;
  assign a_d    = r_a_d;
  assign cs     = r_cs;
  assign rd     = r_rd;
  assign wr     = r_wr;

endmodule
`default_nettype wire
